// File: rtl/shifter_operand_decoder_pkg.sv
// Shared encodings for the ARM data-processing shifter-operand decoder.
// The op_select values match the barrel shifter, and the instruction field positions are defined here.
package shifter_operand_decoder_pkg;

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_RRX = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ_RM = 2'd1,
    ST_READ_RS = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_e;

  localparam int unsigned BIT_I         = 25;
  localparam int unsigned BIT_REG_SHIFT = 4;
  localparam int unsigned BIT_7         = 7;
  localparam int unsigned RM_LSB        = 0;
  localparam int unsigned RS_LSB        = 8;
  localparam int unsigned ROT_LSB       = 8;
  localparam int unsigned IMM8_LSB      = 0;
  localparam int unsigned SH_TYPE_LSB   = 5;
  localparam int unsigned SH_IMM_LSB    = 7;

  // The 8-bit immediate is rotated right by twice the 4-bit rotate field.
  function automatic logic [31:0] imm_rotate_amount(input logic [3:0] rot);
    return {27'd0, rot, 1'b0};
  endfunction

endpackage

// File: rtl/shift_field_decode.sv
// Normalises an immediate-shift field (type and 5-bit amount) into an op_select and a shift amount.
// A zero amount becomes 32 for LSR and ASR, and becomes RRX by 1 for ROR.
module shift_field_decode
  import shifter_operand_decoder_pkg::*;
(
  input  logic [1:0]  i_shift_type,
  input  logic [4:0]  i_shift_imm,
  output logic [2:0]  o_op_select,
  output logic [31:0] o_shift_value
);

  always_comb begin
    o_op_select   = {1'b0, i_shift_type};
    o_shift_value = {27'd0, i_shift_imm};
    if (i_shift_imm == 5'd0) begin
      case (i_shift_type)
        2'b01, 2'b10: o_shift_value = 32'd32;
        2'b11: begin
          o_op_select   = OP_RRX;
          o_shift_value = 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/shifter_operand_decoder.sv
// Decodes the shifter operand of a data-processing instruction into a barrel-shifter bundle,
// reading Rm and Rs from the register file when needed.
module shifter_operand_decoder
  import shifter_operand_decoder_pkg::*;
(
  input  logic        in_clk,
  input  logic        in_reset,
  input  logic        in_instr_valid,
  output logic        out_instr_ready,
  input  logic [31:0] in_instr,
  input  logic        in_cpsr_c,
  output logic [3:0]  out_rf_addr,
  output logic        out_rf_req,
  input  logic [31:0] in_rf_data,
  output logic        out_valid,
  input  logic        in_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_shift_value,
  output logic [2:0]  out_op_select,
  output logic        out_carry,
  output logic        out_bad_encoding
);

  state_e      r_state;
  logic [11:0] r_operand;
  logic        r_carry;
  logic [31:0] r_data;
  logic [31:0] r_shift_value;
  logic [2:0]  r_op;
  logic        r_bad;

  logic [2:0]  w_imm_op;
  logic [31:0] w_imm_value;
  logic        w_accept;
  logic        w_unused;

  assign w_unused = ^{in_instr[31:26], in_instr[24:12]};
  assign w_accept = (r_state == ST_IDLE) && in_instr_valid;

  shift_field_decode u_shift_field_decode (
    .i_shift_type  (r_operand[SH_TYPE_LSB +: 2]),
    .i_shift_imm   (r_operand[SH_IMM_LSB +: 5]),
    .o_op_select   (w_imm_op),
    .o_shift_value (w_imm_value)
  );

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_state       <= ST_IDLE;
      r_operand     <= 12'd0;
      r_carry       <= 1'b0;
      r_data        <= 32'd0;
      r_shift_value <= 32'd0;
      r_op          <= OP_LSL;
      r_bad         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_operand <= in_instr[11:0];
            r_carry   <= in_cpsr_c;
            r_bad     <= 1'b0;
            if (in_instr[BIT_I]) begin
              r_data        <= {24'd0, in_instr[IMM8_LSB +: 8]};
              r_op          <= OP_ROR;
              r_shift_value <= imm_rotate_amount(in_instr[ROT_LSB +: 4]);
              r_state       <= ST_OUTPUT;
            end else begin
              r_state <= ST_READ_RM;
            end
          end
        end
        ST_READ_RM: begin
          r_data <= in_rf_data;
          if (r_operand[BIT_REG_SHIFT] && !r_operand[BIT_7]) begin
            r_state <= ST_READ_RS;
          end else begin
            // Bit 4 and bit 7 both set is a multiply/extension space encoding, not a shift.
            if (r_operand[BIT_REG_SHIFT]) begin
              r_op          <= OP_LSL;
              r_shift_value <= 32'd0;
              r_bad         <= 1'b1;
            end else begin
              r_op          <= w_imm_op;
              r_shift_value <= w_imm_value;
            end
            r_state <= ST_OUTPUT;
          end
        end
        ST_READ_RS: begin
          r_shift_value <= {24'd0, in_rf_data[7:0]};
          r_op          <= {1'b0, r_operand[SH_TYPE_LSB +: 2]};
          r_state       <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (in_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_instr_ready  = (r_state == ST_IDLE) && !in_reset;
  assign out_rf_req       = (r_state == ST_READ_RM) || (r_state == ST_READ_RS);
  assign out_rf_addr      = (r_state == ST_READ_RM) ? r_operand[RM_LSB +: 4] :
                            (r_state == ST_READ_RS) ? r_operand[RS_LSB +: 4] : 4'd0;
  assign out_valid        = (r_state == ST_OUTPUT);
  assign out_data         = r_data;
  assign out_shift_value  = r_shift_value;
  assign out_op_select    = r_op;
  assign out_carry        = r_carry;
  assign out_bad_encoding = r_bad;

endmodule

// File: tb/tb_shifter_operand_decoder.sv
// Randomised bench for shifter_operand_decoder, checked every cycle against a transaction-level model
// and pinned by directed cases with hand-computed values.
module tb_shifter_operand_decoder;

  logic        in_clk = 1'b0;
  logic        in_reset;
  logic        in_instr_valid;
  logic        out_instr_ready;
  logic [31:0] in_instr;
  logic        in_cpsr_c;
  logic [3:0]  out_rf_addr;
  logic        out_rf_req;
  logic [31:0] in_rf_data;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [31:0] out_shift_value;
  logic [2:0]  out_op_select;
  logic        out_carry;
  logic        out_bad_encoding;

  logic [31:0] rf_mem [16];

  int total = 0;
  int bad   = 0;

  always #5 in_clk = ~in_clk;

  assign in_rf_data = out_rf_req ? rf_mem[out_rf_addr] : 32'hDEAD_BEEF;

  shifter_operand_decoder dut (
    .in_clk           (in_clk),
    .in_reset         (in_reset),
    .in_instr_valid   (in_instr_valid),
    .out_instr_ready  (out_instr_ready),
    .in_instr         (in_instr),
    .in_cpsr_c        (in_cpsr_c),
    .out_rf_addr      (out_rf_addr),
    .out_rf_req       (out_rf_req),
    .in_rf_data       (in_rf_data),
    .out_valid        (out_valid),
    .in_ready         (in_ready),
    .out_data         (out_data),
    .out_shift_value  (out_shift_value),
    .out_op_select    (out_op_select),
    .out_carry        (out_carry),
    .out_bad_encoding (out_bad_encoding)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected bundle and latency for one instruction, derived from the operand rules.
  function automatic void model(input logic [31:0] ins, output logic [31:0] d,
                                output logic [31:0] v, output logic [2:0] op,
                                output logic b, output int lat);
    int imm;
    int t;
    int rot;
    b = 1'b0;
    if (ins[25]) begin
      rot = int'(ins[11:8]);
      d   = ins & 32'h0000_00FF;
      v   = 32'(rot * 2);
      op  = 3'd3;
      lat = 1;
    end else begin
      d   = rf_mem[ins[3:0]];
      imm = int'(ins[11:7]);
      t   = int'(ins[6:5]);
      op  = 3'(t);
      if (!ins[4]) begin
        lat = 2;
        v   = 32'(imm);
        if (imm == 0 && (t == 1 || t == 2)) v = 32'd32;
        if (imm == 0 && t == 3) begin
          op = 3'd4;
          v  = 32'd1;
        end
      end else if (ins[7]) begin
        lat = 2;
        op  = 3'd0;
        v   = 32'd0;
        b   = 1'b1;
      end else begin
        lat = 3;
        v   = rf_mem[ins[11:8]] % 256;
      end
    end
  endfunction

  logic        m_busy = 1'b0;
  int          m_age  = 0;
  int          m_lat  = 0;
  logic [31:0] m_ins, m_d, m_v;
  logic [2:0]  m_op;
  logic        m_b, m_c;

  // Compare process: inputs only change just after rising edges, so the falling edge is quiet.
  initial begin
    forever begin
      @(negedge in_clk);
      if (in_reset) begin
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rf_req", 32'(out_rf_req), 32'd0);
        chk("rst_data", out_data, 32'd0);
        m_busy = 1'b0;
      end else if (!m_busy) begin
        chk("idle_ready", 32'(out_instr_ready), 32'd1);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_rf_req", 32'(out_rf_req), 32'd0);
        if (in_instr_valid) begin
          m_ins = in_instr;
          m_c   = in_cpsr_c;
          model(m_ins, m_d, m_v, m_op, m_b, m_lat);
          m_busy = 1'b1;
          m_age  = 1;
        end
      end else begin
        chk("busy_ready", 32'(out_instr_ready), 32'd0);
        if (m_age < m_lat) begin
          chk("pend_valid", 32'(out_valid), 32'd0);
          chk("pend_rf_req", 32'(out_rf_req), 32'd1);
          chk("pend_rf_addr", 32'(out_rf_addr),
              (m_age == 1) ? 32'(m_ins[3:0]) : 32'(m_ins[11:8]));
          m_age++;
        end else begin
          chk("out_valid", 32'(out_valid), 32'd1);
          chk("out_rf_req", 32'(out_rf_req), 32'd0);
          chk("out_data", out_data, m_d);
          chk("out_value", out_shift_value, m_v);
          chk("out_op", 32'(out_op_select), 32'(m_op));
          chk("out_carry", 32'(out_carry), 32'(m_c));
          chk("out_bad", 32'(out_bad_encoding), 32'(m_b));
          if (in_ready) m_busy = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  logic [31:0] p_d, p_v;
  logic [2:0]  p_op;
  logic        p_b;
  int          p_lat;

  initial begin
    in_reset       = 1'b1;
    in_instr_valid = 1'b0;
    in_instr       = 32'd0;
    in_cpsr_c      = 1'b0;
    in_ready       = 1'b1;
    for (int i = 0; i < 16; i++) rf_mem[i] = $urandom;
    rf_mem[2] = 32'h8000_0001;
    rf_mem[3] = 32'h1234_5678;
    rf_mem[4] = 32'hFFFF_FF21;

    // Pin the model with hand-computed values.
    model(32'hE3A0_04FF, p_d, p_v, p_op, p_b, p_lat);
    chk("pin_imm_data", p_d, 32'h0000_00FF);
    chk("pin_imm_value", p_v, 32'd8);
    chk("pin_imm_lat", 32'(p_lat), 32'd1);
    model(32'hE1A0_1022, p_d, p_v, p_op, p_b, p_lat);
    chk("pin_lsr0_value", p_v, 32'd32);
    chk("pin_lsr0_op", 32'(p_op), 32'd1);
    model(32'hE1A0_1413, p_d, p_v, p_op, p_b, p_lat);
    chk("pin_reg_value", p_v, 32'h21);
    chk("pin_reg_lat", 32'(p_lat), 32'd3);

    repeat (3) step();
    in_reset = 1'b0;
    @(negedge in_clk);
    chk("reset_ready", 32'(out_instr_ready), 32'd1);
    chk("reset_op", 32'(out_op_select), 32'd0);
    chk("reset_carry", 32'(out_carry), 32'd0);

    // Immediate operand.
    step();
    in_instr = 32'hE3A0_04FF; in_cpsr_c = 1'b1; in_instr_valid = 1'b1;
    step();
    in_instr_valid = 1'b0; in_cpsr_c = 1'b0;
    @(negedge in_clk);
    chk("imm_valid", 32'(out_valid), 32'd1);
    chk("imm_data", out_data, 32'h0000_00FF);
    chk("imm_op", 32'(out_op_select), 32'd3);
    chk("imm_value", out_shift_value, 32'd8);
    chk("imm_carry", 32'(out_carry), 32'd1);
    step();

    // LSR #0 becomes LSR by 32.
    in_instr = 32'hE1A0_1022; in_instr_valid = 1'b1;
    step();
    in_instr_valid = 1'b0;
    @(negedge in_clk);
    chk("lsr_rf_addr", 32'(out_rf_addr), 32'd2);
    step();
    @(negedge in_clk);
    chk("lsr_data", out_data, 32'h8000_0001);
    chk("lsr_op", 32'(out_op_select), 32'd1);
    chk("lsr_value", out_shift_value, 32'd32);
    step();

    // ROR #0 becomes RRX.
    in_instr = 32'hE1A0_1062; in_cpsr_c = 1'b1; in_instr_valid = 1'b1;
    step();
    in_instr_valid = 1'b0; in_cpsr_c = 1'b0;
    step();
    @(negedge in_clk);
    chk("rrx_op", 32'(out_op_select), 32'd4);
    chk("rrx_value", out_shift_value, 32'd1);
    chk("rrx_carry", 32'(out_carry), 32'd1);
    step();

    // Register shift, then stall the output with in_ready low.
    in_ready = 1'b0;
    in_instr = 32'hE1A0_1413; in_instr_valid = 1'b1;
    step();
    in_instr_valid = 1'b0;
    @(negedge in_clk);
    chk("rs_addr_rm", 32'(out_rf_addr), 32'd3);
    step();
    @(negedge in_clk);
    chk("rs_addr_rs", 32'(out_rf_addr), 32'd4);
    step();
    @(negedge in_clk);
    chk("rs_data", out_data, 32'h1234_5678);
    chk("rs_op", 32'(out_op_select), 32'd0);
    chk("rs_value", out_shift_value, 32'h21);
    repeat (5) begin
      step();
      in_instr = $urandom; in_instr_valid = 1'b1;
      @(negedge in_clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_ready", 32'(out_instr_ready), 32'd0);
      chk("stall_data", out_data, 32'h1234_5678);
      chk("stall_value", out_shift_value, 32'h21);
    end
    step();
    in_instr_valid = 1'b0; in_ready = 1'b1;
    step();
    @(negedge in_clk);
    chk("stall_release", 32'(out_instr_ready), 32'd1);

    // Reset while in READ_RS drops the instruction.
    step();
    in_instr = 32'hE1A0_1413; in_instr_valid = 1'b1;
    step();
    in_instr_valid = 1'b0;
    step();
    in_reset = 1'b1;
    step();
    in_reset = 1'b0;
    @(negedge in_clk);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_rf_req", 32'(out_rf_req), 32'd0);
    chk("rst_mid_ready", 32'(out_instr_ready), 32'd1);
    repeat (4) step();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 16; i++) rf_mem[i] = $urandom;
    for (int n = 0; n < 4000; n++) begin
      step();
      in_reset       = ($urandom_range(0, 149) == 0);
      in_instr_valid = ($urandom_range(0, 1) == 1);
      in_instr       = $urandom;
      if ($urandom_range(0, 2) == 0) in_instr[11:7] = 5'd0;
      if ($urandom_range(0, 3) == 0) in_instr[4] = 1'b1;
      in_cpsr_c      = ($urandom_range(0, 1) == 1);
      in_ready       = ($urandom_range(0, 3) != 0);
    end
    step();
    in_reset = 1'b0; in_instr_valid = 1'b0; in_ready = 1'b1;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
